lsu_bus_master: RTL and testbench
=================================

# lsu_bus_master

Load/store bus initiator sitting between the RISC-V core's memory stage and the memory-mapped IO bus served by the IO peripheral block. Accepts one byte/half/word load or store per request, drives the word-wide bus handshake (ADDR, DIN, WE, RREQ out; DOUT, RDY in) and returns aligned, sign/zero-extended load data. Sub-word stores are performed as read-modify-write, because the bus is word-only. A 1-cycle DONE pulse ends each request; BUSY stalls the pipeline meanwhile.

## Interface
- TIMEOUT_CYCLES, 255: cycles a strobe may wait for RDY before abort (LSU_TIMEOUT_EN only); legal range 1..65535.
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ  in  1  core request strobe, sampled when BUSY=0.
- REQ_WE  in  1  1=store, 0=load.
- REQ_SIZE  in  2  00 byte, 01 half, 10 word; 11 treated as misaligned.
- REQ_UNSIGNED  in  1  loads: 1 zero-extend, 0 sign-extend.
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  32  store data, right-justified.
- BUSY  out  1  request in flight.
- DONE  out  1  1-cycle completion pulse.
- ERR  out  1  valid with DONE: misaligned or timeout.
- RDATA  out  32  load result, valid with DONE, held until next accept.
- ADDR  out  32  bus address, bits [1:0] always 0.
- DIN  out  32  bus write data.
- WE  out  1  bus write strobe.
- RREQ  out  1  bus read strobe.
- DOUT  in  32  bus read data, valid when RDY=1 during read.
- RDY  in  1  slave completion.

## Operation
- States: IDLE, RD, GAP, WR. Reset: IDLE; BUSY, DONE, ERR, WE, RREQ = 0; RDATA, ADDR, DIN = 0.
- IDLE: REQ=1 latches all REQ_* fields. Misaligned (half with addr[0]=1, word with addr[1:0]≠0, size 11) -> stay IDLE, next cycle DONE=1, ERR=1, RDATA=0, no bus activity.
- Load, or sub-word store -> RD (RREQ=1). Word store -> WR (WE=1, DIN=REQ_WDATA).
- RD: RDY=1 captures DOUT. Load: extract lane addr[1:0] (little-endian, byte k = bits 8k+7:8k), extend, -> IDLE with DONE. Store: merge REQ_WDATA low byte/half into captured word at lane -> GAP.
- GAP: one cycle, both strobes low -> WR.
- WR: WE=1, DIN=merged word; RDY=1 -> IDLE with DONE, ERR=0, RDATA unchanged.
- Bus rules: WE and RREQ never high together; ADDR/DIN stable while a strobe is high; strobe drops the cycle after RDY sampled; at least one strobe-low cycle between transactions.
- REQ while BUSY=1 ignored (no queue). RDY while no strobe ignored.
- RST mid-transaction: strobes drop immediately (async), state IDLE, no DONE.

## Timing
- Accept on edge E0; strobe high after E0; RDY sampled at E1 earliest.
- Word load/store, RDY at E1: DONE high E1–E2, BUSY high E0–E1, low in DONE cycle (new REQ accepted at E2).
- Sub-word store, RDY at E1 and E3: RREQ E0–E1, GAP E1–E2, WE E2–E3, DONE E3–E4.
- Each RDY wait of n cycles adds n cycles latency.
- Misaligned: DONE/ERR E0–E1.

## Configuration
- LSU_TIMEOUT_EN defined: 16-bit counter clears on strobe assert, increments each cycle with strobe high and RDY=0; on reaching TIMEOUT_CYCLES strobe drops, -> IDLE, DONE=1, ERR=1, RDATA=0; RMW aborted, no write issued.
- Undefined: no counter; master waits indefinitely for RDY; ERR only for misalignment.

## Test plan
- Word load addr 0x100, DOUT=0x8000_00F0, RDY 1 cycle after RREQ -> ADDR=0x100, one RREQ cycle, DONE with RDATA=0x8000_00F0, ERR=0.
- Byte load addr 0x103 signed, DOUT=0x8A00_0000 -> RDATA=0xFFFF_FF8A; same unsigned -> 0x0000_008A.
- Byte store 0x55 to 0x102, read returns 0x1122_3344 -> RREQ, one idle cycle, WE with DIN=0x1155_3344, DONE ERR=0.
- Half load addr 0x101 -> DONE ERR=1 next cycle, RREQ/WE never asserted.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, RDY held 0 -> RREQ high exactly 4 cycles, then DONE ERR=1 RDATA=0; without macro, RREQ held until RDY.
- RST pulsed during WR of an RMW -> WE low asynchronously, BUSY=0, no DONE; next word load completes normally.

Source files
------------

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: load/store initiator for the word-only IO bus.
// Sub-word stores use read-modify-write. Optional RDY timeout: LSU_TIMEOUT_EN.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic [31:0] ADDR,
  output logic [31:0] DIN,
  output logic        WE,
  output logic        RREQ,
  input  logic [31:0] DOUT,
  input  logic        RDY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  logic [1:0]  state_q, state_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        st_q, st_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wlo_q, wlo_d;

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  logic        misal;
  logic [4:0]  sh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_val;
  logic [31:0] mask;
  logic [31:0] ins;
  logic [31:0] merged;

  // Strobes follow the state register, so async reset drops them at once.
  assign BUSY  = (state_q != S_IDLE);
  assign RREQ  = (state_q == S_RD);
  assign WE    = (state_q == S_WR);
  assign DONE  = done_q;
  assign ERR   = err_q;
  assign RDATA = rdata_q;
  assign ADDR  = addr_q;
  assign DIN   = din_q;

  // Alignment check on the incoming request and lane datapath on bus data.
  always_comb begin
    misal  = (REQ_SIZE == 2'b11)
           | ((REQ_SIZE == 2'b01) & REQ_ADDR[0])
           | ((REQ_SIZE == 2'b10) & (|REQ_ADDR[1:0]));
    sh     = {lane_q, 3'b000};
    lane_b = 8'(DOUT >> sh);
    lane_h = 16'(DOUT >> sh);
    case (size_q)
      2'b00:   ld_val = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   ld_val = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: ld_val = DOUT;
    endcase
    if (size_q == 2'b00) begin
      mask = 32'h0000_00FF << sh;
      ins  = {24'h0, wlo_q[7:0]} << sh;
    end else begin
      mask = 32'h0000_FFFF << sh;
      ins  = {16'h0, wlo_q} << sh;
    end
    merged = (DOUT & ~mask) | ins;
  end

  // Next-state logic for the request FSM and its registered outputs.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    din_d   = din_q;
    st_d    = st_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    wlo_d   = wlo_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          if (misal) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            st_d   = REQ_WE;
            size_d = REQ_SIZE;
            uns_d  = REQ_UNSIGNED;
            lane_d = REQ_ADDR[1:0];
            wlo_d  = REQ_WDATA[15:0];
            addr_d = {REQ_ADDR[31:2], 2'b00};
`ifdef LSU_TIMEOUT_EN
            cnt_d  = 16'h0;
`endif
            if (REQ_WE && REQ_SIZE == 2'b10) begin
              din_d   = REQ_WDATA;
              state_d = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        if (RDY) begin
          if (!st_q) begin
            rdata_d = ld_val;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            din_d   = merged;
            state_d = S_GAP;
          end
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
`endif
      end
      S_GAP: begin
        state_d = S_WR;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = 16'h0;
`endif
      end
      default: begin
        if (RDY) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
`endif
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      addr_q  <= 32'h0;
      din_q   <= 32'h0;
      st_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      wlo_q   <= 16'h0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= 16'h0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      st_q    <= st_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      wlo_q   <= wlo_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: directed bench for lsu_bus_master.
// Timeout scenario follows LSU_TIMEOUT_EN.
module tb_lsu_bus_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic        REQ_WE = 1'b0;
  logic [1:0]  REQ_SIZE = 2'b00;
  logic        REQ_UNSIGNED = 1'b0;
  logic [31:0] REQ_ADDR = 32'h0;
  logic [31:0] REQ_WDATA = 32'h0;
  logic        BUSY, DONE, ERR, WE, RREQ;
  logic [31:0] RDATA, ADDR, DIN;
  logic [31:0] DOUT = 32'h0;
  logic        RDY = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WE(REQ_WE),
    .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
    .ADDR(ADDR), .DIN(DIN), .WE(WE), .RREQ(RREQ),
    .DOUT(DOUT), .RDY(RDY)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic un, input logic [31:0] a,
                       input logic [31:0] wd);
    REQ = 1'b1; REQ_WE = we; REQ_SIZE = sz;
    REQ_UNSIGNED = un; REQ_ADDR = a; REQ_WDATA = wd;
    step();
    REQ = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(); step();
    n_cmp++;
    if ({BUSY, DONE, ERR, WE, RREQ} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctl got %b want 00000",
                        {BUSY, DONE, ERR, WE, RREQ});
    end
    n_cmp++;
    if ({RDATA, ADDR, DIN} !== 96'h0) begin
      n_bad++; $display("FAIL reset_data got %h %h %h want 0", RDATA, ADDR, DIN);
    end
    RST = 1'b0;
    step();
  endtask

  task automatic test_word_load();
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    n_cmp++;
    if ({RREQ, WE, BUSY} !== 3'b101 || ADDR !== 32'h100) begin
      n_bad++; $display("FAIL wl_strobe got %b %h want 101 00000100",
                        {RREQ, WE, BUSY}, ADDR);
    end
    RDY = 1'b1; DOUT = 32'h8000_00F0;
    step();
    RDY = 1'b0;
    n_cmp++;
    if ({DONE, ERR, RREQ, BUSY} !== 4'b1000 || RDATA !== 32'h8000_00F0) begin
      n_bad++; $display("FAIL wl_done got %b %h want 1000 800000f0",
                        {DONE, ERR, RREQ, BUSY}, RDATA);
    end
    step();
    n_cmp++;
    if (DONE !== 1'b0) begin
      n_bad++; $display("FAIL wl_pulse got %b want 0", DONE);
    end
  endtask

  task automatic test_sub_load();
    logic [31:0] exp_v [4];
    logic [31:0] dv [4];
    logic [31:0] av [4];
    logic [1:0]  sv [4];
    logic        uv [4];
    exp_v = '{32'hFFFF_FF8A, 32'h0000_008A, 32'hFFFF_BEEF, 32'h0000_BEEF};
    dv    = '{32'h8A00_0000, 32'h8A00_0000, 32'hBEEF_1234, 32'hBEEF_1234};
    av    = '{32'h103, 32'h103, 32'h102, 32'h102};
    sv    = '{2'b00, 2'b00, 2'b01, 2'b01};
    uv    = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, sv[i], uv[i], av[i], 32'h0);
      n_cmp++;
      if (ADDR !== 32'h100 || RREQ !== 1'b1) begin
        n_bad++; $display("FAIL sl_addr%0d got %h %b want 00000100 1",
                          i, ADDR, RREQ);
      end
      RDY = 1'b1; DOUT = dv[i];
      step();
      RDY = 1'b0;
      n_cmp++;
      if (DONE !== 1'b1 || ERR !== 1'b0 || RDATA !== exp_v[i]) begin
        n_bad++; $display("FAIL sl_data%0d got %b%b %h want 10 %h",
                          i, DONE, ERR, RDATA, exp_v[i]);
      end
      step();
    end
  endtask

  task automatic test_byte_store();
    issue(1'b1, 2'b00, 1'b0, 32'h102, 32'hAAAA_AA55);
    n_cmp++;
    if ({RREQ, WE} !== 2'b10 || ADDR !== 32'h100) begin
      n_bad++; $display("FAIL bs_rd got %b %h want 10 00000100", {RREQ, WE}, ADDR);
    end
    RDY = 1'b1; DOUT = 32'h1122_3344;
    step();
    RDY = 1'b0;
    n_cmp++;
    if ({RREQ, WE, BUSY, DONE} !== 4'b0010) begin
      n_bad++; $display("FAIL bs_gap got %b want 0010", {RREQ, WE, BUSY, DONE});
    end
    step();
    n_cmp++;
    if ({RREQ, WE} !== 2'b01 || DIN !== 32'h1155_3344 || ADDR !== 32'h100) begin
      n_bad++; $display("FAIL bs_wr got %b %h %h want 01 11553344 00000100",
                        {RREQ, WE}, DIN, ADDR);
    end
    RDY = 1'b1;
    step();
    RDY = 1'b0;
    n_cmp++;
    if ({DONE, ERR, WE} !== 3'b100 || RDATA !== 32'h0000_BEEF) begin
      n_bad++; $display("FAIL bs_done got %b %h want 100 0000beef",
                        {DONE, ERR, WE}, RDATA);
    end
    step();
  endtask

  task automatic test_misaligned();
    logic [31:0] av [3];
    logic [1:0]  sv [3];
    av = '{32'h101, 32'h102, 32'h100};
    sv = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, sv[i], 1'b0, av[i], 32'h0);
      n_cmp++;
      if ({DONE, ERR, RREQ, WE, BUSY} !== 5'b11000 || RDATA !== 32'h0) begin
        n_bad++; $display("FAIL mis%0d got %b %h want 11000 0",
                          i, {DONE, ERR, RREQ, WE, BUSY}, RDATA);
      end
      step();
      n_cmp++;
      if ({DONE, ERR, RREQ, WE} !== 4'b0000) begin
        n_bad++; $display("FAIL mis_after%0d got %b want 0000",
                          i, {DONE, ERR, RREQ, WE});
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEAD_BEEF);
    n_cmp++;
    if ({WE, RREQ} !== 2'b10 || DIN !== 32'hDEAD_BEEF || ADDR !== 32'h200) begin
      n_bad++; $display("FAIL bb_wr got %b %h %h want 10 deadbeef 00000200",
                        {WE, RREQ}, DIN, ADDR);
    end
    RDY = 1'b1;
    REQ = 1'b1; REQ_WE = 1'b0; REQ_SIZE = 2'b10; REQ_ADDR = 32'h204;
    step();
    RDY = 1'b0;
    n_cmp++;
    if ({DONE, ERR, WE, RREQ, BUSY} !== 5'b10000 || RDATA !== 32'h0) begin
      n_bad++; $display("FAIL bb_done got %b %h want 10000 0",
                        {DONE, ERR, WE, RREQ, BUSY}, RDATA);
    end
    step();
    REQ = 1'b0;
    n_cmp++;
    if ({RREQ, DONE} !== 2'b10 || ADDR !== 32'h204) begin
      n_bad++; $display("FAIL bb_next got %b %h want 10 00000204", {RREQ, DONE}, ADDR);
    end
    RDY = 1'b1; DOUT = 32'hCAFE_F00D;
    step();
    RDY = 1'b0;
    n_cmp++;
    if (DONE !== 1'b1 || RDATA !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL bb_ld got %b %h want 1 cafef00d", DONE, RDATA);
    end
    step();
  endtask

  task automatic test_wait_timeout();
    int hi;
    hi = 0;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
      if (RREQ !== 1'b1) break;
      hi++;
      step();
    end
    n_cmp++;
    if (hi !== 4) begin
      n_bad++; $display("FAIL to_len got %0d want 4", hi);
    end
    n_cmp++;
    if ({DONE, ERR, RREQ, BUSY} !== 4'b1100 || RDATA !== 32'h0) begin
      n_bad++; $display("FAIL to_done got %b %h want 1100 0",
                        {DONE, ERR, RREQ, BUSY}, RDATA);
    end
    step();
`else
    for (int i = 0; i < 11; i++) begin
      if (RREQ === 1'b1 && DONE === 1'b0) hi++;
      if (i < 10) step();
    end
    n_cmp++;
    if (hi !== 11) begin
      n_bad++; $display("FAIL wait_len got %0d want 11", hi);
    end
    RDY = 1'b1; DOUT = 32'h1234_5678;
    step();
    RDY = 1'b0;
    n_cmp++;
    if ({DONE, ERR, RREQ} !== 3'b100 || RDATA !== 32'h1234_5678) begin
      n_bad++; $display("FAIL wait_done got %b %h want 100 12345678",
                        {DONE, ERR, RREQ}, RDATA);
    end
    step();
`endif
  endtask

  task automatic test_reset_mid_rmw();
    issue(1'b1, 2'b01, 1'b0, 32'h100, 32'h0000_ABCD);
    RDY = 1'b1; DOUT = 32'h1122_3344;
    step();
    RDY = 1'b0;
    step();
    n_cmp++;
    if (WE !== 1'b1 || DIN !== 32'h1122_ABCD) begin
      n_bad++; $display("FAIL rr_wr got %b %h want 1 1122abcd", WE, DIN);
    end
    #3 RST = 1'b1;
    #1;
    n_cmp++;
    if ({WE, RREQ, BUSY, DONE} !== 4'b0000) begin
      n_bad++; $display("FAIL rr_async got %b want 0000", {WE, RREQ, BUSY, DONE});
    end
    RDY = 1'b1;
    step();
    RST = 1'b0; RDY = 1'b0;
    step();
    n_cmp++;
    if ({DONE, BUSY, WE} !== 3'b000) begin
      n_bad++; $display("FAIL rr_nodone got %b want 000", {DONE, BUSY, WE});
    end
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    RDY = 1'b1; DOUT = 32'h0BAD_C0DE;
    step();
    RDY = 1'b0;
    n_cmp++;
    if ({DONE, ERR} !== 2'b10 || RDATA !== 32'h0BAD_C0DE) begin
      n_bad++; $display("FAIL rr_next got %b %h want 10 0badc0de", {DONE, ERR}, RDATA);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_sub_load();
    test_byte_store();
    test_misaligned();
    test_back_to_back();
    test_wait_timeout();
    test_reset_mid_rmw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
